mlp_train_sequencer: RTL

//  Upstream stage of the MLP. Holds a small training dataset and presents one sample at a

---
 rtl/mlp_train_sequencer_pkg.sv | 30 +++
 rtl/mlp_train_sequencer_if.sv | 44 ++++
 rtl/mlp_train_sequencer_mem.sv | 63 ++++++
 rtl/mlp_train_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mlp_train_sequencer_pkg.sv
// Shared state encoding, default geometry and the binary-cross-entropy helper
// used by the MLP training sequencer and its dataset store.
package mlp_train_sequencer_pkg;

    localparam int  DEF_INPUTS        = 2;
    localparam int  DEF_OUTPUTS       = 1;
    localparam int  DEF_DEPTH         = 4;
    localparam int  DEF_SETTLE_CYCLES = 2;
    localparam int  DEF_EPOCH_W       = 16;

    // Keeps ln() finite when the prediction saturates at 0.0 or 1.0.
    localparam real EPSILON = 1.0e-7;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRAIN,
        ADVANCE,
        DONE
    } seq_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic real bce_loss(input real e, input real p);
        return -(e * $ln(p + EPSILON) + (1.0 - e) * $ln(1.0 - p + EPSILON));
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_if.sv
// Control, dataset-load and MLP-facing signals of the training sequencer.
// The driving controller/MLP side uses master; the sequencer uses slave.
interface mlp_train_sequencer_if import mlp_train_sequencer_pkg::*; #(
    parameter int INPUTS  = DEF_INPUTS,
    parameter int OUTPUTS = DEF_OUTPUTS,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int EPOCH_W = DEF_EPOCH_W
);
    localparam int IDX_W = idx_width(DEPTH);

    logic               load_valid;
    logic               load_ready;
    real                load_values   [INPUTS];
    real                load_expected [OUTPUTS];
    logic               clear;
    logic               start;
    logic               abort;
    logic [EPOCH_W-1:0] num_epochs;
    real                values        [INPUTS];
    real                expected      [OUTPUTS];
    real                prediction    [OUTPUTS];
    logic               training;
    logic [IDX_W-1:0]   sample_idx;
    logic [EPOCH_W-1:0] epoch_count;
    real                epoch_loss;
    logic               loss_valid;
    logic               busy;
    logic               done;

    modport master (
        output load_valid, load_values, load_expected, clear, start, abort,
               num_epochs, prediction,
        input  load_ready, values, expected, training, sample_idx, epoch_count,
               epoch_loss, loss_valid, busy, done
    );

    modport slave (
        input  load_valid, load_values, load_expected, clear, start, abort,
               num_epochs, prediction,
        output load_ready, values, expected, training, sample_idx, epoch_count,
               epoch_loss, loss_valid, busy, done
    );

endinterface

// File: rtl/mlp_train_sequencer_mem.sv
// DEPTH-entry dataset register file: appends at the fill count, clears by
// resetting the count, and reads asynchronously at the requested index.
module mlp_dataset_mem import mlp_train_sequencer_pkg::*; #(
    parameter int INPUTS  = DEF_INPUTS,
    parameter int OUTPUTS = DEF_OUTPUTS,
    parameter int DEPTH   = DEF_DEPTH,
    localparam int IDX_W  = idx_width(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  real              wr_values_i   [INPUTS],
    input  real              wr_expected_i [OUTPUTS],
    input  logic [IDX_W-1:0] rd_idx_i,
    output real              rd_values_o   [INPUTS],
    output real              rd_expected_o [OUTPUTS],
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    real              mem_values_q   [DEPTH][INPUTS];
    real              mem_expected_q [DEPTH][OUTPUTS];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wr_fire;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign wr_fire = wr_en_i && !clear_i && !full_o;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (wr_fire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_values_q[count_q[IDX_W-1:0]]   <= wr_values_i;
            mem_expected_q[count_q[IDX_W-1:0]] <= wr_expected_i;
        end
    end

    assign rd_values_o   = mem_values_q[rd_idx_i];
    assign rd_expected_o = mem_expected_q[rd_idx_i];
    assign count_o       = count_q;

endmodule

// File: rtl/mlp_train_sequencer.sv
// Presents stored samples to the MLP one at a time, pulses training after a
// settle window, accumulates per-epoch BCE loss and reports run completion.
module mlp_train_sequencer import mlp_train_sequencer_pkg::*; #(
    parameter int INPUTS        = DEF_INPUTS,
    parameter int OUTPUTS       = DEF_OUTPUTS,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int EPOCH_W       = DEF_EPOCH_W
) (
    input logic                  clk,
    input logic                  rst,
    mlp_train_sequencer_if.slave bus
);

    localparam int               IDX_W       = idx_width(DEPTH);
    localparam int               CNT_W       = $clog2(DEPTH + 1);
    localparam int               SET_W       = idx_width(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0]   sample_idx_q, sample_idx_d;
    logic [EPOCH_W-1:0] epoch_count_q, epoch_count_d;
    logic [EPOCH_W-1:0] num_epochs_q, num_epochs_d;
    real                epoch_loss_q, epoch_loss_d;
    real                acc_q, acc_d;
    logic               loss_valid_q, loss_valid_d;
    real                values_q   [INPUTS];
    real                expected_q [OUTPUTS];

    real                rd_values   [INPUTS];
    real                rd_expected [OUTPUTS];
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               clear_en;
    logic               load_ready;
    logic               write_fire;
    logic               start_ok;
    logic               last_sample;
    logic               load_sample;
    logic [EPOCH_W-1:0] epoch_inc;
    real                sample_loss;

    assign clear_en    = (state_q == IDLE) && bus.clear;
    assign load_ready  = (state_q == IDLE) && !full;
    assign write_fire  = bus.load_valid && load_ready && !clear_en;
    assign last_sample = ((CNT_W'(sample_idx_q) + CNT_W'(1)) == count);
    assign epoch_inc   = epoch_count_q + EPOCH_W'(1);

    // A run never starts alongside a write or clear, so count is stable for the whole run.
    assign start_ok = (state_q == IDLE) && bus.start && !bus.abort && !clear_en &&
                      !write_fire && (count != '0) && (bus.num_epochs != '0);

    mlp_dataset_mem #(
        .INPUTS  (INPUTS),
        .OUTPUTS (OUTPUTS),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear_en),
        .wr_en_i       (write_fire),
        .wr_values_i   (bus.load_values),
        .wr_expected_i (bus.load_expected),
        .rd_idx_i      (sample_idx_d),
        .rd_values_o   (rd_values),
        .rd_expected_o (rd_expected),
        .count_o       (count),
        .full_o        (full)
    );

    always_comb begin
        sample_loss = 0.0;
        for (int o = 0; o < OUTPUTS; o++) begin
            sample_loss = sample_loss + bce_loss(expected_q[o], bus.prediction[o]);
        end
    end

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        sample_idx_d  = sample_idx_q;
        epoch_count_d = epoch_count_q;
        num_epochs_d  = num_epochs_q;
        epoch_loss_d  = epoch_loss_q;
        acc_d         = acc_q;
        loss_valid_d  = 1'b0;

        if (state_q != IDLE && bus.abort) begin
            state_d       = IDLE;
            sample_idx_d  = '0;
            epoch_count_d = '0;
            acc_d         = 0.0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_d       = SETTLE;
                        settle_cnt_d  = '0;
                        sample_idx_d  = '0;
                        epoch_count_d = '0;
                        num_epochs_d  = bus.num_epochs;
                        acc_d         = 0.0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        acc_d   = acc_q + sample_loss;
                        state_d = TRAIN;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SET_W'(1);
                    end
                end
                TRAIN: begin
                    state_d = ADVANCE;
                end
                ADVANCE: begin
                    settle_cnt_d = '0;
                    if (last_sample) begin
                        sample_idx_d  = '0;
                        epoch_count_d = epoch_inc;
                        epoch_loss_d  = acc_q / real'(count);
                        loss_valid_d  = 1'b1;
                        acc_d         = 0.0;
                        state_d       = (epoch_inc == num_epochs_q) ? DONE : SETTLE;
                    end else begin
                        sample_idx_d = sample_idx_q + IDX_W'(1);
                        state_d      = SETTLE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The presented sample is captured once, on entry to its settle window.
    assign load_sample = (state_d == SETTLE) && (state_q != SETTLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            sample_idx_q  <= '0;
            epoch_count_q <= '0;
            num_epochs_q  <= '0;
            epoch_loss_q  <= 0.0;
            acc_q         <= 0.0;
            loss_valid_q  <= 1'b0;
            for (int i = 0; i < INPUTS; i++) values_q[i] <= 0.0;
            for (int o = 0; o < OUTPUTS; o++) expected_q[o] <= 0.0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            sample_idx_q  <= sample_idx_d;
            epoch_count_q <= epoch_count_d;
            num_epochs_q  <= num_epochs_d;
            epoch_loss_q  <= epoch_loss_d;
            acc_q         <= acc_d;
            loss_valid_q  <= loss_valid_d;
            if (load_sample) begin
                values_q   <= rd_values;
                expected_q <= rd_expected;
            end
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.values      = values_q;
    assign bus.expected    = expected_q;
    assign bus.training    = (state_q == TRAIN);
    assign bus.sample_idx  = sample_idx_q;
    assign bus.epoch_count = epoch_count_q;
    assign bus.epoch_loss  = epoch_loss_q;
    assign bus.loss_valid  = loss_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);

endmodule
